// File: rtl/execute.sv
// SEQ Y86-64 execute stage: ALU producing valE, condition evaluation (Cnd) and the ZF/SF/OF register.
// Optional sticky halt flag that freezes the condition codes: enabled by defining EXECUTE_HALT_LATCH_EN.
module execute (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [63:0] valE,
  output logic        Cnd,
  output logic        ZF,
  output logic        SF,
  output logic        OF,
  output logic        halted
);

  typedef enum logic [3:0] {
    I_HALT  = 4'h0, I_NOP  = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3,
    I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OP  = 4'h6, I_JXX   = 4'h7,
    I_CALL  = 4'h8, I_RET  = 4'h9, I_PUSH = 4'hA, I_POP   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_XOR = 4'h3
  } alu_op_e;

  logic [63:0] alu_res;
  logic        op_valid;
  logic        alu_of;
  logic        cc_freeze;
  logic        cc_en;
  logic        zf_q, sf_q, of_q;

  // NOTE: every output of a combinational block is assigned a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (alu_op_e'(ifun))
      ALU_ADD: begin
        alu_res = valB + valA;
        alu_of  = (valA[63] == valB[63]) && (alu_res[63] != valB[63]);
      end
      ALU_SUB: begin
        alu_res = valB - valA;
        alu_of  = (valA[63] != valB[63]) && (alu_res[63] != valB[63]);
      end
      ALU_AND: alu_res = valB & valA;
      ALU_XOR: alu_res = valB ^ valA;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    valE = '0;
    case (icode_e'(icode))
      I_CMOV:           valE = valA;
      I_IRMOV:          valE = valC;
      I_RMMOV, I_MRMOV: valE = valB + valC;
      I_OP:             valE = alu_res;
      I_CALL, I_PUSH:   valE = valB - 64'd8;
      I_RET, I_POP:     valE = valB + 64'd8;
      default:          valE = '0;
    endcase
  end

  // Conditions read only the registered flags, never this cycle's ALU result.
  always_comb begin
    Cnd = 1'b0;
    if (icode == I_CMOV || icode == I_JXX) begin
      case (ifun)
        4'h0:    Cnd = 1'b1;
        4'h1:    Cnd = (sf_q ^ of_q) | zf_q;
        4'h2:    Cnd = sf_q ^ of_q;
        4'h3:    Cnd = zf_q;
        4'h4:    Cnd = ~zf_q;
        4'h5:    Cnd = ~(sf_q ^ of_q);
        4'h6:    Cnd = ~(sf_q ^ of_q) & ~zf_q;
        default: Cnd = 1'b0;
      endcase
    end
  end

  assign op_valid = (icode == I_OP) && (ifun <= ALU_XOR);

`ifdef EXECUTE_HALT_LATCH_EN
  logic halted_q, halted_d;

  assign halted_d  = halted_q || (icode == I_HALT) || (icode > I_POP);
  assign cc_freeze = halted_q;
  assign halted    = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`else
  assign cc_freeze = 1'b0;
  assign halted    = 1'b0;
`endif

  assign cc_en = op_valid && !cc_freeze;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_en) begin
      zf_q <= (alu_res == 64'd0);
      sf_q <= alu_res[63];
      of_q <= alu_of;
    end
  end

  assign ZF = zf_q;
  assign SF = sf_q;
  assign OF = of_q;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: reset-held vector table, directed multi-cycle sequences,
// and randomized cycles against an arithmetic reference model.
module tb_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic [63:0] valE;
  logic        Cnd, ZF, SF, OF, halted;

  int n_cmp  = 0;
  int n_fail = 0;

  logic m_zf, m_sf, m_of, m_halt;

  execute dut (
    .clk(clk), .reset(reset), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC),
    .valE(valE), .Cnd(Cnd), .ZF(ZF), .SF(SF), .OF(OF), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] e;
    logic        cnd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, want 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written from the instruction semantics.
  function automatic logic [63:0] m_vale(input logic [3:0] ic, fn, input logic [63:0] a, b, c);
    case (ic)
      2:       return a;
      3:       return c;
      4, 5:    return b + c;
      6: case (fn)
           0:       return b + a;
           1:       return b - a;
           2:       return b & a;
           3:       return b ^ a;
           default: return 64'd0;
         endcase
      8, 10:   return b - 8;
      9, 11:   return b + 8;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic m_cnd(input logic [3:0] ic, fn, input logic zf, sf, of);
    logic less;
    less = (sf != of);
    if (ic != 2 && ic != 7) return 1'b0;
    case (fn)
      0:       return 1'b1;
      1:       return less || zf;
      2:       return less;
      3:       return zf;
      4:       return !zf;
      5:       return !less;
      6:       return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Signed-range view of overflow: the true signed result does not fit in 64 bits.
  task automatic model_edge(input logic [3:0] ic, fn, input logic [63:0] a, b, c);
    longint sa, sb, sr;
    logic [63:0] r;
    logic frozen;
    frozen = 1'b0;
`ifdef EXECUTE_HALT_LATCH_EN
    frozen = m_halt;
    if (ic == 0 || ic > 11) m_halt = 1'b1;
`endif
    if (ic == 6 && fn <= 3 && !frozen) begin
      r  = m_vale(ic, fn, a, b, c);
      sa = a; sb = b; sr = r;
      m_zf = (r == 0);
      m_sf = (sr < 0);
      case (fn)
        0:       m_of = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
        1:       m_of = (sb >= 0 && sa < 0 && sr < 0) || (sb < 0 && sa >= 0 && sr >= 0);
        default: m_of = 1'b0;
      endcase
    end
  endtask

  task automatic model_reset();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_halt = 1'b0;
  endtask

  // One SEQ cycle: inputs applied just after an edge, combinational outputs checked before the
  // next edge, flags checked just after it.
  task automatic run_cycle(input logic [3:0] ic, fn, input logic [63:0] a, b, c);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    #2;
    check("valE", valE, m_vale(ic, fn, a, b, c));
    check("Cnd", {63'd0, Cnd}, {63'd0, m_cnd(ic, fn, m_zf, m_sf, m_of)});
    @(posedge clk);
    model_edge(ic, fn, a, b, c);
    #1;
    check("ZF", {63'd0, ZF}, {63'd0, m_zf});
    check("SF", {63'd0, SF}, {63'd0, m_sf});
    check("OF", {63'd0, OF}, {63'd0, m_of});
    check("halted", {63'd0, halted}, {63'd0, m_halt});
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [3:0] r_ic, r_fn;

    vecs.push_back(vec_t'{4'h1, 4'h0, 64'h5, 64'h6, 64'h7, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'h2, 4'h0, 64'h1234, 64'h9, 64'h7, 64'h1234, 1'b1});
    vecs.push_back(vec_t'{4'h2, 4'h4, 64'hABCD, 64'h9, 64'h7, 64'hABCD, 1'b0});
    vecs.push_back(vec_t'{4'h3, 4'h0, 64'h1, 64'h2, 64'hDEAD, 64'hDEAD, 1'b0});
    vecs.push_back(vec_t'{4'h4, 4'h0, 64'h1, 64'd3, 64'd10, 64'd13, 1'b0});
    vecs.push_back(vec_t'{4'h5, 4'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0});
    vecs.push_back(vec_t'{4'h6, 4'h0, 64'd5, 64'd7, 64'h0, 64'd12, 1'b0});
    vecs.push_back(vec_t'{4'h6, 4'h1, 64'd5, 64'd7, 64'h0, 64'd2, 1'b0});
    vecs.push_back(vec_t'{4'h6, 4'h2, 64'hF0, 64'h3C, 64'h0, 64'h30, 1'b0});
    vecs.push_back(vec_t'{4'h6, 4'h3, 64'hF0, 64'h3C, 64'h0, 64'hCC, 1'b0});
    vecs.push_back(vec_t'{4'h6, 4'h4, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'h6, 4'hF, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'h7, 4'h1, 64'h3, 64'h4, 64'h5, 64'h0, 1'b1});
    vecs.push_back(vec_t'{4'h7, 4'h2, 64'h3, 64'h4, 64'h5, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'h7, 4'h3, 64'h3, 64'h4, 64'h5, 64'h0, 1'b1});
    vecs.push_back(vec_t'{4'h7, 4'h5, 64'h3, 64'h4, 64'h5, 64'h0, 1'b1});
    vecs.push_back(vec_t'{4'h7, 4'h6, 64'h3, 64'h4, 64'h5, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'h7, 4'h8, 64'h3, 64'h4, 64'h5, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'h8, 4'h0, 64'h3, 64'h100, 64'h5, 64'hF8, 1'b0});
    vecs.push_back(vec_t'{4'h9, 4'h0, 64'h3, 64'hF8, 64'h5, 64'h100, 1'b0});
    vecs.push_back(vec_t'{4'hA, 4'h0, 64'h3, 64'h0, 64'h5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0});
    vecs.push_back(vec_t'{4'hB, 4'h0, 64'h3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'hC, 4'h0, 64'h3, 64'h4, 64'h5, 64'h0, 1'b0});
    vecs.push_back(vec_t'{4'h0, 4'h0, 64'h3, 64'h4, 64'h5, 64'h0, 1'b0});

    reset = 1'b1; icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    model_reset();
    #2;
    check("rst_ZF", {63'd0, ZF}, 64'd1);
    check("rst_SF", {63'd0, SF}, 64'd0);
    check("rst_OF", {63'd0, OF}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_valE", valE, 64'd0);

    // Table applied with reset held, so flags stay at their reset values throughout.
    foreach (vecs[i]) begin
      icode = vecs[i].ic; ifun = vecs[i].fn;
      valA = vecs[i].a; valB = vecs[i].b; valC = vecs[i].c;
      #1;
      check($sformatf("vec%0d_valE", i), valE, vecs[i].e);
      check($sformatf("vec%0d_Cnd", i), {63'd0, Cnd}, {63'd0, vecs[i].cnd});
    end
    icode = 4'h1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Signed overflow on add, then jl must see SF^OF = 0.
    run_cycle(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    check("add_ovf_ZF", {63'd0, ZF}, 64'd0);
    check("add_ovf_SF", {63'd0, SF}, 64'd1);
    check("add_ovf_OF", {63'd0, OF}, 64'd1);
    run_cycle(4'h7, 4'h2, 64'd0, 64'd0, 64'h40);
    run_cycle(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    check("sub_eq_ZF", {63'd0, ZF}, 64'd1);
    icode = 4'h2; ifun = 4'h3; valA = 64'h55AA; #2;
    check("cmove_Cnd", {63'd0, Cnd}, 64'd1);
    check("cmove_valE", valE, 64'h55AA);
    @(posedge clk); #1;
    run_cycle(4'h4, 4'h0, 64'd0, 64'd3, 64'd10);
    run_cycle(4'h8, 4'h0, 64'd0, 64'h100, 64'd0);
    run_cycle(4'h9, 4'h0, 64'd0, 64'hF8, 64'd0);
    run_cycle(4'h6, 4'h5, 64'd9, 64'd3, 64'd0);
    check("bad_ifun_ZF", {63'd0, ZF}, 64'd1);

    // Randomized cycles; halt-class icodes are kept out so the flags stay live.
    for (int n = 0; n < 400; n++) begin
      r_ic = ($urandom_range(0, 2) == 0) ? 4'(6) : 4'($urandom_range(1, 11));
      r_fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      run_cycle(r_ic, r_fn, rand_val(), rand_val(), rand_val());
    end

    // Asynchronous reset pulse between edges.
    icode = 4'h1; #1;
    reset = 1'b1; #1;
    model_reset();
    check("async_ZF", {63'd0, ZF}, 64'd1);
    check("async_SF", {63'd0, SF}, 64'd0);
    check("async_OF", {63'd0, OF}, 64'd0);
    check("async_valE", valE, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Halt followed by sub 1-2: frozen CC with the latch, SF=1 without it.
    run_cycle(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
    run_cycle(4'h6, 4'h1, 64'd2, 64'd1, 64'd0);
`ifdef EXECUTE_HALT_LATCH_EN
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_SF", {63'd0, SF}, 64'd0);
    reset = 1'b1; #1;
    model_reset();
    check("halt_cleared", {63'd0, halted}, 64'd0);
    reset = 1'b0;
`else
    check("nohalt_flag", {63'd0, halted}, 64'd0);
    check("nohalt_SF", {63'd0, SF}, 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the SEQ Y86-64 processor. It sits directly upstream of the memory stage and produces `valE`, which memory uses as the data address (rmmovq/mrmovq/call/push) and the writeback stage uses as the result. It also produces `Cnd` for cmovXX/jXX. It owns the architectural condition-code register (ZF/SF/OF), which updates on the clock edge only for OPq.

## Interface
Parameters: none.
- `clk` input 1: system clock; CC register updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `icode` input 4: instruction code from fetch/decode.
- `ifun` input 4: function code (ALU op or condition).
- `valA` input 64: decode operand A.
- `valB` input 64: decode operand B (rB value or %rsp).
- `valC` input 64: instruction constant.
- `valE` output 64: ALU result, combinational.
- `Cnd` output 1: condition result, combinational from registered CC.
- `ZF`, `SF`, `OF` output 1 each: registered condition codes.
- `halted` output 1: sticky halt flag (see Configuration).

## Operation
- valE by icode (two's-complement 64-bit arithmetic, carry out discarded):
  - 2 cmovXX: valA.
  - 3 irmovq: valC.
  - 4 rmmovq, 5 mrmovq: valB + valC.
  - 6 OPq, by ifun: 0 valB+valA, 1 valB−valA, 2 valB&valA, 3 valB^valA, 4–F: 0.
  - 8 call, A pushq: valB − 8.
  - 9 ret, B popq: valB + 8.
  - 0, 1, 7, C–F: 0.
- CC next-state, only when icode=6 and ifun≤3:
  - ZF = (result==0).
  - SF = result[63].
  - OF for add: valA[63]==valB[63] && result[63]!=valB[63].
  - OF for sub: valA[63]!=valB[63] && result[63]!=valB[63].
  - OF for and/xor: 0.
- Otherwise CC holds its value.
- Cnd applies only for icode 2 or 7, else 0. By ifun:
  - 0: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - 7–F: 0.

## Timing
- valE and Cnd are combinational, with zero-cycle latency within the SEQ cycle.
- CC captures on the rising edge of `clk` at the end of the OPq cycle. An instruction in the next cycle sees the new flags.
- Cnd always uses the pre-edge (registered) flags.
- Reset is asynchronous and takes effect immediately regardless of `clk`:
  - ZF=1, SF=0, OF=0, halted=0.
  - Reset asserted mid-cycle overrides any pending OPq update.
- On the first rising edge after reset deasserts, normal update rules apply.
- An OPq with an invalid ifun (4–F) leaves CC unchanged.

## Configuration
- `EXECUTE_HALT_LATCH_EN` defined:
  - `halted` sets on a rising edge when icode=0 or icode>0xB, and stays set until reset.
  - While halted=1, CC updates are suppressed even for valid OPq.
  - valE and Cnd continue to evaluate normally.
- Undefined: `halted` is tied to 0 and CC is never frozen.

## Test plan
- Reset pulse with no clock edge → ZF=1, SF=0, OF=0, halted=0, valE=0 for icode=1.
- icode=6, ifun=0, valA=0x7FFFFFFFFFFFFFFF, valB=1, then clock edge:
  - valE=0x8000000000000000 before the edge.
  - After the edge: ZF=0, SF=1, OF=1.
  - Then icode=7, ifun=2 → Cnd=0 (SF^OF=0).
- icode=6, ifun=1, valA=5, valB=5, then edge → valE=0, ZF=1, SF=0, OF=0. Then icode=2, ifun=3 → Cnd=1, valE=valA.
- Address/stack ops:
  - icode=4, valB=3, valC=10 → valE=13.
  - icode=8, valB=0x100 → valE=0xF8.
  - icode=9, valB=0xF8 → valE=0x100.
  - CC unchanged across edges for all three.
- icode=6, ifun=5, then edge → valE=0, CC unchanged.
- Halt and reset behaviour:
  - With `EXECUTE_HALT_LATCH_EN`: icode=0 then edge → halted=1. A following OPq sub 1−2 then edge leaves CC unchanged. Reset → halted=0.
  - Without the macro: the same sequence sets SF=1.
